// File: rtl/alu_mc_pkg.sv
// Shared op codes, FSM states and constant rules for the multi-cycle ALU.
// ALU_MC_DIV_EN adds the DIV state; op codes are always declared.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OpAdd   = 4'h0,
        OpSub   = 4'h1,
        OpAnd   = 4'h2,
        OpOr    = 4'h3,
        OpSrl   = 4'h4,
        OpSra   = 4'h5,
        OpSll   = 4'h6,
        OpXor   = 4'h7,
        OpSlt   = 4'h8,
        OpSltu  = 4'h9,
        OpMult  = 4'hA,
        OpMultu = 4'hB,
        OpDiv   = 4'hC,
        OpDivu  = 4'hD
    } op_e;

`ifdef ALU_MC_DIV_EN
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StHold} state_e;
`else
    typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;
`endif

    localparam int MAX_WIDTH = 64;

    // Quotient returned for a zero divisor: all ones at the given width.
    function automatic logic [MAX_WIDTH-1:0] div_zero_quot(input int width);
        return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/alu_mc_muldiv_seq.sv
// Iterative shift-add multiplier and restoring divider on operand magnitudes.
// The divider is present only when ALU_MC_DIV_EN is defined.
module alu_mc_muldiv_seq
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
`ifdef ALU_MC_DIV_EN
    input  logic             i_is_div,
`endif
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               r_busy;
    logic               r_neg;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_op;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_hi_nx;
    logic [WIDTH-1:0]   w_lo_nx;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod;

    assign w_a_mag = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // {r_hi, r_lo} is the partial product; r_lo starts as the multiplier and shifts out.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
    assign {w_mul_hi, w_mul_lo} = {w_mul_sum, r_lo[WIDTH-1:1]};
    assign w_prod = r_neg ? -{w_mul_hi, w_mul_lo} : {w_mul_hi, w_mul_lo};

    // Sign fixup is folded into the final iteration so done coincides with the last step.
    assign o_done = r_busy && (r_cnt == LAST);

`ifdef ALU_MC_DIV_EN
    localparam logic [MAX_WIDTH-1:0] DZ_FULL = div_zero_quot(WIDTH);

    logic             r_is_div;
    logic             r_neg_rem;
    logic             r_b_zero;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    // r_hi holds the partial remainder, r_lo shifts dividend bits out and quotient bits in.
    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_op};
    assign w_div_hi = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};
    assign w_hi_nx  = r_is_div ? w_div_hi : w_mul_hi;
    assign w_lo_nx  = r_is_div ? w_div_lo : w_mul_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_div  <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
        end else if (i_start) begin
            r_is_div  <= i_is_div;
            r_neg_rem <= i_signed && i_a[WIDTH-1];
            r_b_zero  <= (i_b == '0);
        end
    end

    always_comb begin
        {o_hi, o_lo} = w_prod;
        if (r_is_div) begin
            o_lo = r_b_zero ? DZ_FULL[WIDTH-1:0] : (r_neg ? -w_div_lo : w_div_lo);
            o_hi = r_neg_rem ? -w_div_hi : w_div_hi;
        end
    end
`else
    assign w_hi_nx = w_mul_hi;
    assign w_lo_nx = w_mul_lo;
    assign {o_hi, o_lo} = w_prod;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_neg  <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_op   <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_neg  <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= w_a_mag;
            r_op   <= w_b_mag;
        end else if (r_busy) begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative MUL (and DIV when
// ALU_MC_DIV_EN is defined) behind valid/ready handshakes on both sides.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e           r_state, w_state_d;
    logic             r_out_valid, w_valid_d;
    logic [WIDTH-1:0] r_result, w_result_d;
    logic [WIDTH-1:0] r_result_hi, w_result_hi_d;
    logic             r_zero, w_zero_d;
    logic             r_ovf, w_ovf_d;
    logic             r_illegal, w_illegal_d;

    logic             w_accept;
    logic             w_is_seq;
    logic             w_signed;
    logic             w_done;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic             w_alu_ill;
    logic [WIDTH-1:0] w_seq_lo;
    logic [WIDTH-1:0] w_seq_hi;

    assign in_ready = !reset && (r_state == StIdle) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_signed = (op == OpMult) || (op == OpDiv);

`ifdef ALU_MC_DIV_EN
    logic w_is_div;
    assign w_is_div = (op == OpDiv) || (op == OpDivu);
    assign w_is_seq = (op == OpMult) || (op == OpMultu) || w_is_div;
`else
    assign w_is_seq = (op == OpMult) || (op == OpMultu);
`endif

    alu_mc_muldiv_seq #(
        .WIDTH(WIDTH)
    ) u_seq (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_accept && w_is_seq),
`ifdef ALU_MC_DIV_EN
        .i_is_div(w_is_div),
`endif
        .i_signed(w_signed),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_done),
        .o_lo    (w_seq_lo),
        .o_hi    (w_seq_hi)
    );

    assign w_shamt = b[SHW-1:0];
    assign w_sum   = a + b;
    assign w_diff  = a - b;

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        w_alu_ill = 1'b0;
        case (op)
            OpAdd: begin
                w_alu_res = w_sum;
                w_alu_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OpSub: begin
                w_alu_res = w_diff;
                w_alu_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            OpAnd:   w_alu_res = a & b;
            OpOr:    w_alu_res = a | b;
            OpSrl:   w_alu_res = a >> w_shamt;
            OpSra:   w_alu_res = $signed(a) >>> w_shamt;
            OpSll:   w_alu_res = a << w_shamt;
            OpXor:   w_alu_res = a ^ b;
            OpSlt:   w_alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OpSltu:  w_alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OpMult, OpMultu: w_alu_res = '0;
`ifdef ALU_MC_DIV_EN
            OpDiv, OpDivu:   w_alu_res = '0;
`endif
            default: w_alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_state_d     = r_state;
        w_valid_d     = r_out_valid;
        w_result_d    = r_result;
        w_result_hi_d = r_result_hi;
        w_zero_d      = r_zero;
        w_ovf_d       = r_ovf;
        w_illegal_d   = r_illegal;
        case (r_state)
            StIdle: begin
                if (w_accept && w_is_seq) begin
                    w_valid_d = 1'b0;
`ifdef ALU_MC_DIV_EN
                    w_state_d = w_is_div ? StDiv : StMul;
`else
                    w_state_d = StMul;
`endif
                end else if (w_accept) begin
                    w_valid_d     = 1'b1;
                    w_result_d    = w_alu_res;
                    w_result_hi_d = '0;
                    w_zero_d      = (w_alu_res == '0);
                    w_ovf_d       = w_alu_ovf;
                    w_illegal_d   = w_alu_ill;
                end else if (out_ready) begin
                    w_valid_d = 1'b0;
                end
            end
`ifdef ALU_MC_DIV_EN
            StMul, StDiv: begin
`else
            StMul: begin
`endif
                if (w_done) begin
                    w_state_d     = StHold;
                    w_valid_d     = 1'b1;
                    w_result_d    = w_seq_lo;
                    w_result_hi_d = w_seq_hi;
                    w_zero_d      = (w_seq_lo == '0);
                    w_ovf_d       = 1'b0;
                    w_illegal_d   = 1'b0;
                end
            end
            StHold: begin
                if (out_ready) begin
                    w_state_d = StIdle;
                    w_valid_d = 1'b0;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_out_valid <= w_valid_d;
            r_result    <= w_result_d;
            r_result_hi <= w_result_hi_d;
            r_zero      <= w_zero_d;
            r_ovf       <= w_ovf_d;
            r_illegal   <= w_illegal_d;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zero      = r_zero;
    assign overflow  = r_ovf;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed test-plan vectors plus random ops against an arithmetic model.
module tb_alu_mc;
    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] obs_lo;
    logic [31:0] obs_hi;
    logic        obs_ovf;
    logic        obs_ill;

    always #5 clk = ~clk;

    alu_mc #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .result_hi(result_hi),
        .zero     (zero),
        .overflow (overflow),
        .illegal  (illegal)
    );

    initial begin
        #3000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_seq(input logic [3:0] o);
`ifdef ALU_MC_DIV_EN
        return (o >= 4'd10) && (o <= 4'd13);
`else
        return (o == 4'd10) || (o == 4'd11);
`endif
    endfunction

    // Reference behaviour from plain 64-bit arithmetic.
    function automatic void model(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic z, output logic ov, output logic il);
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] p;
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        lo = '0;
        hi = '0;
        ov = 1'b0;
        il = 1'b0;
        case (o)
            4'd0: begin s = sa + sb; lo = xa + xb; ov = (s > SMAX) || (s < SMIN); end
            4'd1: begin s = sa - sb; lo = xa - xb; ov = (s > SMAX) || (s < SMIN); end
            4'd2: lo = xa & xb;
            4'd3: lo = xa | xb;
            4'd4: lo = xa >> xb[4:0];
            4'd5: lo = 32'(sa >>> xb[4:0]);
            4'd6: lo = xa << xb[4:0];
            4'd7: lo = xa ^ xb;
            4'd8: lo = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: lo = (xa < xb) ? 32'd1 : 32'd0;
            4'd10: begin p = 64'(sa * sb); {hi, lo} = p; end
            4'd11: begin p = {32'd0, xa} * {32'd0, xb}; {hi, lo} = p; end
`ifdef ALU_MC_DIV_EN
            4'd12: begin
                if (xb == 32'd0) begin lo = '1; hi = xa; end
                else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
            end
            4'd13: begin
                if (xb == 32'd0) begin lo = '1; hi = xa; end
                else begin lo = xa / xb; hi = xa % xb; end
            end
`endif
            default: il = 1'b1;
        endcase
        z = (lo == 32'd0);
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                         input string tag);
        logic [31:0] elo;
        logic [31:0] ehi;
        logic        ez;
        logic        eov;
        logic        eil;
        int          exp_lat;
        int          lat;
        int          rdy_seen;
        model(o, xa, xb, elo, ehi, ez, eov, eil);
        exp_lat = is_seq(o) ? W + 1 : 1;
        wait_ready(tag);
        in_valid = 1'b1;
        op = o;
        a = xa;
        b = xb;
        @(negedge clk);
        // Operands only need to be valid in the accept cycle.
        in_valid = 1'b0;
        op = 4'($urandom);
        a = $urandom;
        b = $urandom;
        lat = 1;
        rdy_seen = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen++;
            @(negedge clk);
            lat++;
        end
        obs_lo = result;
        obs_hi = result_hi;
        obs_ovf = overflow;
        obs_ill = illegal;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(result), 64'(elo));
        check({tag, "_result_hi"}, 64'(result_hi), 64'(ehi));
        check({tag, "_zero"}, 64'(zero), 64'(ez));
        check({tag, "_overflow"}, 64'(overflow), 64'(eov));
        check({tag, "_illegal"}, 64'(illegal), 64'(eil));
        if (exp_lat > 1) check({tag, "_busy_in_ready"}, 64'(rdy_seen), 64'd0);
    endtask

    initial begin
        int          seen;
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        op = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_result_hi", 64'(result_hi), 64'd0);
        check("rst_flags", 64'({zero, overflow, illegal}), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        do_op(4'd0, 32'h7FFF_FFFF, 32'd1, "add_ovf");
        check("add_ovf_const", 64'({obs_lo, obs_ovf}), 64'({32'h8000_0000, 1'b1}));
        do_op(4'd5, 32'h8000_0000, 32'hFFFF_FF24, "sra");
        check("sra_const", 64'(obs_lo), 64'h0000_0000_F800_0000);
        do_op(4'd4, 32'h8000_0000, 32'hFFFF_FF24, "srl");
        check("srl_const", 64'(obs_lo), 64'h0000_0000_0800_0000);
        do_op(4'd10, 32'hFFFF_FFFD, 32'd5, "mult");
        check("mult_const", {obs_hi, obs_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op(4'd1, 32'h8000_0000, 32'd1, "sub_ovf");
        do_op(4'd8, 32'hFFFF_FFFF, 32'd1, "slt");
        do_op(4'd9, 32'hFFFF_FFFF, 32'd1, "sltu");
        do_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
        do_op(4'd14, 32'd9, 32'd9, "ill14");
        check("ill14_const", 64'({obs_lo, obs_ill}), 64'd1);
        do_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
        do_op(4'd13, 32'd7, 32'd0, "divu_zero");
        do_op(4'd12, 32'hFFFF_FFF9, 32'd2, "div_neg");
`ifdef ALU_MC_DIV_EN
        check("divu_zero_const", {obs_hi, obs_lo}, 64'h0000_0007_FFFF_FFFF);
        do_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, "div_min2");
        check("div_min_const", {obs_hi, obs_lo}, 64'h0000_0000_8000_0000);
`else
        check("div_off_const", 64'({obs_lo, obs_ill}), 64'd1);
`endif

        // Back-pressure: let the last output drain, then stall a fresh ADD.
        wait_ready("bp_pre");
        @(negedge clk);
        out_ready = 1'b0;
        do_op(4'd0, 32'd2, 32'd3, "bp_add");
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (result !== 32'd5 || !out_valid || in_ready) seen++;
        end
        check("bp_held", 64'(seen), 64'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);

        // Reset 10 cycles into a MULTU abandons it.
        wait_ready("rst_mul_pre");
        in_valid = 1'b1;
        op = 4'd11;
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        repeat (9) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mul_in_ready", 64'(in_ready), 64'd1);
        check("rst_mul_out_valid", 64'(out_valid), 64'd0);
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_mul_no_output", 64'(seen), 64'd0);
        do_op(4'd0, 32'd1, 32'd1, "post_rst_add");
        check("post_rst_add_const", 64'(obs_lo), 64'd2);

        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (i % 7 == 0) rb = 32'd0;
            if (i % 11 == 0) ra = 32'h8000_0000;
            if (i % 5 == 1) rb = rb & 32'h0000_00FF;
            do_op(ro, ra, rb, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
